coeff_bank_loader: RTL and testbench

Receiving end of the Master Control coefficient-write stream. It accepts 32-bit coefficient write commands, checks opcode and sequence, and writes coefficients into a shadow bank of the LPF-X, LPF-Y and HPF coefficient memories. A complete, error-free load session swaps the shadow bank into active service atomically. The filter datapaths read coefficients from the active bank through three registered read ports.

---
 rtl/coeff_bank_loader.sv | 188 ++++++++++++++++++
 tb/tb_coeff_bank_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_bank_loader.sv
// Receiving end of the coefficient-write stream: validates one load session into
// the shadow bank of three coefficient memories and swaps banks on a clean commit.
module coeff_bank_loader #(
  parameter int         LPF_X_COEFF = 32,
  parameter int         LPF_Y_COEFF = 32,
  parameter int         HPF_COEFF   = 96,
  parameter logic [7:0] LPF_X_WE_OP = 8'h44,
  parameter logic [7:0] LPF_Y_WE_OP = 8'h45,
  parameter logic [7:0] HPF_WE_OP   = 8'h46
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        we_coeff,
  input  logic [31:0] cr_coeff,
  input  logic        coeff_busy,
  input  logic [7:0]  lpf_x_addr,
  input  logic [7:0]  lpf_y_addr,
  input  logic [7:0]  hpf_addr,
  output logic [15:0] lpf_x_coeff,
  output logic [15:0] lpf_y_coeff,
  output logic [15:0] hpf_coeff,
  output logic        coeff_valid,
  output logic        coeff_loaded,
  output logic        coeff_err,
  output logic [1:0]  err_code
);

  localparam int AW_X = (LPF_X_COEFF > 1) ? $clog2(LPF_X_COEFF) : 1;
  localparam int AW_Y = (LPF_Y_COEFF > 1) ? $clog2(LPF_Y_COEFF) : 1;
  localparam int AW_H = (HPF_COEFF   > 1) ? $clog2(HPF_COEFF)   : 1;
  localparam logic [7:0] N_X = 8'(LPF_X_COEFF);
  localparam logic [7:0] N_Y = 8'(LPF_Y_COEFF);
  localparam logic [7:0] N_H = 8'(HPF_COEFF);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK} state_t;
  typedef enum logic [1:0] {
    ERR_NONE       = 2'b00,
    ERR_OPCODE     = 2'b01,
    ERR_SEQ        = 2'b10,
    ERR_INCOMPLETE = 2'b11
  } err_t;

  state_t     state, state_d;
  err_t       err_code_q, code_d;
  logic       bank_sel, bank_sel_d;
  logic [7:0] cnt_x, cnt_y, cnt_h;
  logic [7:0] cnt_x_d, cnt_y_d, cnt_h_d;
  logic       valid_d, loaded_d, err_d;
  logic       start, full;
  logic       wr_x, wr_y, wr_h;

  logic [15:0] mem_x [2][LPF_X_COEFF];
  logic [15:0] mem_y [2][LPF_Y_COEFF];
  logic [15:0] mem_h [2][HPF_COEFF];

  logic [15:0] w_data;
  logic [7:0]  w_idx, w_op;

  assign w_data   = cr_coeff[31:16];
  assign w_idx    = cr_coeff[15:8];
  assign w_op     = cr_coeff[7:0];
  assign full     = (cnt_x == N_X) && (cnt_y == N_Y) && (cnt_h == N_H);
  assign err_code = err_code_q;

  // NOTE: every sequential process uses non-blocking assignments so all
  // registers update together from pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= S_IDLE;
      bank_sel     <= 1'b0;
      cnt_x        <= '0;
      cnt_y        <= '0;
      cnt_h        <= '0;
      coeff_valid  <= 1'b0;
      coeff_loaded <= 1'b0;
      coeff_err    <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state        <= state_d;
      bank_sel     <= bank_sel_d;
      cnt_x        <= cnt_x_d;
      cnt_y        <= cnt_y_d;
      cnt_h        <= cnt_h_d;
      coeff_valid  <= valid_d;
      coeff_loaded <= loaded_d;
      coeff_err    <= err_d;
      err_code_q   <= code_d;
    end
  end

  // NOTE: each variable gets a default before any branch so no path holds a
  // stale value and no latch is inferred.
  always_comb begin
    state_d    = state;
    bank_sel_d = bank_sel;
    cnt_x_d    = cnt_x;
    cnt_y_d    = cnt_y;
    cnt_h_d    = cnt_h;
    valid_d    = coeff_valid;
    loaded_d   = 1'b0;
    err_d      = coeff_err;
    code_d     = err_code_q;
    wr_x       = 1'b0;
    wr_y       = 1'b0;
    wr_h       = 1'b0;
    start      = (state == S_IDLE) && coeff_busy;

    // A write arriving with the busy rise sees the freshly cleared session.
    if (start) begin
      cnt_x_d = '0;
      cnt_y_d = '0;
      cnt_h_d = '0;
      err_d   = 1'b0;
      code_d  = ERR_NONE;
    end

    case (state)
      S_IDLE:  if (coeff_busy) state_d = S_LOAD;
      S_LOAD:  if (!coeff_busy) state_d = S_CHECK;
      S_CHECK: begin
        state_d = S_IDLE;
        if (!coeff_err) begin
          if (full) begin
            bank_sel_d = ~bank_sel;
            valid_d    = 1'b1;
            loaded_d   = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_INCOMPLETE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state == S_LOAD || start) && we_coeff && !err_d) begin
      if (w_op == LPF_X_WE_OP) begin
        if (w_idx == cnt_x_d && cnt_x_d < N_X && cnt_y_d == 8'd0 && cnt_h_d == 8'd0) begin
          wr_x    = 1'b1;
          cnt_x_d = cnt_x_d + 8'd1;
        end else begin
          err_d  = 1'b1;
          code_d = ERR_SEQ;
        end
      end else if (w_op == LPF_Y_WE_OP) begin
        if (cnt_x_d == N_X && w_idx == cnt_y_d && cnt_y_d < N_Y && cnt_h_d == 8'd0) begin
          wr_y    = 1'b1;
          cnt_y_d = cnt_y_d + 8'd1;
        end else begin
          err_d  = 1'b1;
          code_d = ERR_SEQ;
        end
      end else if (w_op == HPF_WE_OP) begin
        if (cnt_y_d == N_Y && w_idx == cnt_h_d && cnt_h_d < N_H) begin
          wr_h    = 1'b1;
          cnt_h_d = cnt_h_d + 8'd1;
        end else if (!(w_idx == N_H && cnt_h_d == N_H)) begin
          err_d  = 1'b1;
          code_d = ERR_SEQ;
        end
      end else begin
        err_d  = 1'b1;
        code_d = ERR_OPCODE;
      end
    end
  end

  // NOTE: coefficient storage has no reset; only the bank pointer and the
  // counters are cleared, and a reset forces a full reload before use.
  always_ff @(posedge sys_clk) begin
    if (wr_x) mem_x[~bank_sel][w_idx[AW_X-1:0]] <= w_data;
    if (wr_y) mem_y[~bank_sel][w_idx[AW_Y-1:0]] <= w_data;
    if (wr_h) mem_h[~bank_sel][w_idx[AW_H-1:0]] <= w_data;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      lpf_x_coeff <= '0;
      lpf_y_coeff <= '0;
      hpf_coeff   <= '0;
    end else begin
      lpf_x_coeff <= (lpf_x_addr < N_X) ? mem_x[bank_sel][lpf_x_addr[AW_X-1:0]] : 16'h0000;
      lpf_y_coeff <= (lpf_y_addr < N_Y) ? mem_y[bank_sel][lpf_y_addr[AW_Y-1:0]] : 16'h0000;
      hpf_coeff   <= (hpf_addr   < N_H) ? mem_h[bank_sel][hpf_addr[AW_H-1:0]]   : 16'h0000;
    end
  end

endmodule

// File: tb/tb_coeff_bank_loader.sv
// Scoreboard bench for coeff_bank_loader: a stream-position reference model
// queues expected status and read data; a monitor compares them when due.
module tb_coeff_bank_loader;

  localparam int NX    = 32;
  localparam int NY    = 32;
  localparam int NH    = 96;
  localparam int TOTAL = NX + NY + NH;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        we_coeff = 1'b0;
  logic [31:0] cr_coeff = '0;
  logic        coeff_busy = 1'b0;
  logic [7:0]  lpf_x_addr = '0, lpf_y_addr = '0, hpf_addr = '0;
  logic [15:0] lpf_x_coeff, lpf_y_coeff, hpf_coeff;
  logic        coeff_valid, coeff_loaded, coeff_err;
  logic [1:0]  err_code;

  coeff_bank_loader dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .we_coeff(we_coeff), .cr_coeff(cr_coeff),
    .coeff_busy(coeff_busy), .lpf_x_addr(lpf_x_addr), .lpf_y_addr(lpf_y_addr),
    .hpf_addr(hpf_addr), .lpf_x_coeff(lpf_x_coeff), .lpf_y_coeff(lpf_y_coeff),
    .hpf_coeff(hpf_coeff), .coeff_valid(coeff_valid), .coeff_loaded(coeff_loaded),
    .coeff_err(coeff_err), .err_code(err_code)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct { int due; bit ld; bit vld; bit err; logic [1:0] code; } stat_t;
  typedef struct { int due; logic [15:0] ex, ey, eh; bit cx, cy, ch; } rd_t;
  stat_t stat_q[$];
  rd_t   rd_q[$];

  // Reference model: both banks, active pointer, session status, stream position.
  logic [15:0] ref_mem [3][2][256];
  bit          ref_known [3][2][256];
  bit          ref_sel = 1'b0, ref_valid = 1'b0, ref_err = 1'b0;
  logic [1:0]  ref_code = 2'b00;
  int          pos = 0;
  bit          rd_en = 1'b0;
  logic [31:0] sess_q[$];

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int count_of(input int f);
    return (f == 0) ? NX : (f == 1) ? NY : NH;
  endfunction

  function automatic logic [15:0] exp_rd(input int f, input int a, output bit ok);
    if (a >= count_of(f)) begin
      ok = 1'b1;
      return 16'h0000;
    end
    ok = ref_known[f][ref_sel][a];
    return ref_mem[f][ref_sel][a];
  endfunction

  // Word at position p of the ideal stream; p == TOTAL is the terminator.
  function automatic logic [31:0] ideal(input int p, input logic [15:0] d);
    if (p < NX)             return {d, 8'(p), 8'h44};
    else if (p < NX + NY)   return {d, 8'(p - NX), 8'h45};
    else if (p < TOTAL)     return {d, 8'(p - NX - NY), 8'h46};
    else                    return {d, 8'(NH), 8'h46};
  endfunction

  stat_t ms;
  rd_t   mr;
  always @(negedge sys_clk) begin
    while (stat_q.size() > 0 && stat_q[0].due <= cyc) begin
      ms = stat_q.pop_front();
      check("coeff_loaded", 32'(coeff_loaded), 32'(ms.ld));
      check("coeff_valid", 32'(coeff_valid), 32'(ms.vld));
      check("coeff_err", 32'(coeff_err), 32'(ms.err));
      check("err_code", 32'(err_code), 32'(ms.code));
    end
    while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
      mr = rd_q.pop_front();
      if (mr.cx) check("lpf_x_coeff", 32'(lpf_x_coeff), 32'(mr.ex));
      if (mr.cy) check("lpf_y_coeff", 32'(lpf_y_coeff), 32'(mr.ey));
      if (mr.ch) check("hpf_coeff", 32'(hpf_coeff), 32'(mr.eh));
    end
  end

  int    ra, rb, rc;
  rd_t   rr;
  always @(negedge sys_clk) begin
    if (rd_en) begin
      if (cyc % 8 == 0)      begin ra = NX - 1; rb = 5;  rc = NH - 1; end
      else if (cyc % 8 == 4) begin ra = NX;     rb = NY; rc = NH;     end
      else begin
        ra = $urandom_range(0, NX + 3);
        rb = $urandom_range(0, NY + 3);
        rc = $urandom_range(0, NH + 3);
      end
      lpf_x_addr = 8'(ra);
      lpf_y_addr = 8'(rb);
      hpf_addr   = 8'(rc);
      rr.due = cyc + 1;
      rr.ex  = exp_rd(0, ra, rr.cx);
      rr.ey  = exp_rd(1, rb, rr.cy);
      rr.eh  = exp_rd(2, rc, rr.ch);
      rd_q.push_back(rr);
    end
  end

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic push_stat(input int due, input bit ld);
    stat_t s;
    s.due = due; s.ld = ld; s.vld = ref_valid; s.err = ref_err; s.code = ref_code;
    stat_q.push_back(s);
  endtask

  task automatic push_zero_reads();
    rd_t r;
    r.due = cyc + 1; r.ex = '0; r.ey = '0; r.eh = '0; r.cx = 1; r.cy = 1; r.ch = 1;
    rd_q.push_back(r);
  endtask

  task automatic set_err(input logic [1:0] code);
    ref_err  = 1'b1;
    ref_code = code;
    push_stat(cyc + 1, 1'b0);
  endtask

  task automatic apply_word(input logic [31:0] w);
    logic [7:0]  op, idx;
    logic [31:0] iw;
    int          f;
    op  = w[7:0];
    idx = w[15:8];
    iw  = ideal(pos, 16'h0000);
    if (ref_err) return;
    if (op != 8'h44 && op != 8'h45 && op != 8'h46) set_err(2'b01);
    else if (pos < TOTAL && w[15:0] == iw[15:0]) begin
      f = (pos < NX) ? 0 : (pos < NX + NY) ? 1 : 2;
      ref_mem[f][!ref_sel][idx]   = w[31:16];
      ref_known[f][!ref_sel][idx] = 1'b1;
      pos++;
    end else if (!(pos == TOTAL && op == 8'h46 && idx == 8'(NH))) set_err(2'b10);
  endtask

  task automatic build_full(input bit rnd, input logic [15:0] bx, by, bh);
    logic [15:0] d;
    sess_q.delete();
    for (int p = 0; p <= TOTAL; p++) begin
      if (rnd)                d = 16'($urandom);
      else if (p < NX)        d = bx + 16'(p);
      else if (p < NX + NY)   d = by + 16'(p - NX);
      else                    d = bh + 16'(p - NX - NY);
      sess_q.push_back(ideal(p, d));
    end
  endtask

  task automatic do_reset();
    rd_en = 1'b0;
    we_coeff = 1'b0;
    tick();
    tick();
    sys_rst = 1'b1;
    coeff_busy = 1'b0;
    ref_sel = 1'b0; ref_valid = 1'b0; ref_err = 1'b0; ref_code = 2'b00;
    push_stat(cyc + 1, 1'b0);
    push_zero_reads();
    tick();
    tick();
    push_stat(cyc + 1, 1'b0);
    push_zero_reads();
    tick();
    tick();
    sys_rst = 1'b0;
    rd_en = 1'b1;
    repeat (2) tick();
  endtask

  // gap < 0 draws a random gap per word; stop_at/rst_at < 0 disable them.
  task automatic run_session(input int gap, input int stop_at, input int rst_at);
    int  g;
    bit  commit;
    pos = 0; ref_err = 1'b0; ref_code = 2'b00;
    for (int k = 0; k < sess_q.size(); k++) begin
      if (k == stop_at) break;
      tick();
      g = (gap < 0) ? $urandom_range(0, 3) : gap;
      if (k > 0) for (int j = 0; j < g; j++) begin we_coeff = 1'b0; tick(); end
      if (k == rst_at) begin
        do_reset();
        return;
      end
      coeff_busy = 1'b1;
      we_coeff   = 1'b1;
      cr_coeff   = sess_q[k];
      apply_word(sess_q[k]);
    end
    tick();
    we_coeff   = 1'b0;
    coeff_busy = 1'b0;
    commit = !ref_err && pos == TOTAL;
    if (commit) ref_valid = 1'b1;
    else if (!ref_err) begin ref_err = 1'b1; ref_code = 2'b11; end
    push_stat(cyc + 2, commit);
    push_stat(cyc + 3, 1'b0);
    @(posedge sys_clk);
    @(posedge sys_clk);
    if (commit) ref_sel = !ref_sel;
    repeat (3) tick();
  endtask

  logic [31:0] tw;
  initial begin
    tick();
    push_stat(cyc + 1, 1'b0);
    push_zero_reads();
    repeat (2) tick();
    sys_rst = 1'b0;
    rd_en = 1'b1;
    repeat (3) tick();

    build_full(1'b0, 16'h1000, 16'h2000, 16'h3000);
    run_session(2, -1, -1);
    build_full(1'b0, 16'h4000, 16'h5000, 16'h6000);
    run_session(0, -1, -1);
    build_full(1'b1, '0, '0, '0);
    tw = sess_q[70]; tw[7:0] = 8'h47; sess_q[70] = tw;
    run_session(-1, -1, -1);
    build_full(1'b1, '0, '0, '0);
    sess_q.delete(7);
    run_session(-1, -1, -1);
    build_full(1'b1, '0, '0, '0);
    run_session(-1, -1, -1);
    build_full(1'b1, '0, '0, '0);
    run_session(-1, -1, 50);
    build_full(1'b1, '0, '0, '0);
    run_session(-1, 40, -1);
    build_full(1'b1, '0, '0, '0);
    run_session(1, -1, -1);
    for (int s = 0; s < 3; s++) begin
      build_full(1'b1, '0, '0, '0);
      if (s != 0) begin
        ra = $urandom_range(0, TOTAL);
        tw = sess_q[ra]; tw[15:8] = 8'($urandom_range(0, 99)); sess_q[ra] = tw;
      end
      run_session(-1, -1, -1);
    end

    rd_en = 1'b0;
    repeat (4) tick();
    check("stat_queue_drained", 32'(stat_q.size()), 32'd0);
    check("read_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
